// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline run-control unit.
//   cmd_e       : command codes carried on the debug command bus
//   state_e     : run-control state encoding (also exported as o_state)
//   drain_width : width of a counter able to hold N_STAGES-1
//   DRAIN_W     : drain counter width for the default five-stage pipeline
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_RUN    = 3'd1,
    CMD_STEP   = 3'd2,
    CMD_HALT   = 3'd3,
    CMD_CLEAR  = 3'd4,
    CMD_SET_BP = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int N_STAGES_DEFAULT = 5;

  // A one-stage pipeline would still need a one-bit counter, hence the floor.
  function automatic int drain_width(input int n_stages);
    return (n_stages < 2) ? 1 : $clog2(n_stages);
  endfunction

  localparam int DRAIN_W = drain_width(N_STAGES_DEFAULT);

endpackage

// File: rtl/pipeline_run_ctrl_if.sv
// pipeline_run_ctrl_if
// Command handshake between the debug front-end and the run-control unit.
//   i_cmd_valid : command offered by the front-end
//   i_cmd       : command code (see pipe_ctrl_pkg::cmd_e)
//   i_cmd_data  : breakpoint address for SET_BP
//   o_cmd_ready : run-control can accept a command this cycle
// Modports: master = debug front-end, slave = run-control unit.
interface pipeline_run_ctrl_if #(
  parameter int NB_CMD     = 3,
  parameter int NB_ADDRESS = 32
);
  logic                  i_cmd_valid;
  logic [NB_CMD-1:0]     i_cmd;
  logic [NB_ADDRESS-1:0] i_cmd_data;
  logic                  o_cmd_ready;

  modport master (
    output i_cmd_valid,
    output i_cmd,
    output i_cmd_data,
    input  o_cmd_ready
  );

  modport slave (
    input  i_cmd_valid,
    input  i_cmd,
    input  i_cmd_data,
    output o_cmd_ready
  );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// pipe_ctrl_sat_counter
// Saturating up-counter with synchronous clear.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset (count -> 0)
//   enable : count one step this cycle
//   clear  : synchronous clear, takes priority over enable
//   count  : current value, sticks at all-ones
module pipe_ctrl_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  // Clear wins over counting; once all-ones the value is held.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl
// Run-control unit for the MIPS pipeline: accepts RUN/STEP/HALT/CLEAR/SET_BP
// commands, drives the global stage enable and fetch enable, drains the
// pipeline after a fetched HALT instruction and counts enabled cycles.
// Ports:
//   i_clk, i_reset  : clock, synchronous active-high reset
//   cmd_bus         : command handshake (pipeline_run_ctrl_if.slave)
//   i_halt_fetched  : IF holds a HALT instruction this cycle
//   i_pc            : current IF PC (breakpoint compare only)
//   o_pipe_en       : global stage-register enable
//   o_fetch_en      : PC/IF enable
//   o_state         : 0 IDLE, 1 RUN, 2 STEP, 3 DONE
//   o_cycle_count   : saturating count of enabled cycles
//   o_done          : one-cycle pulse on entering DONE
//   o_cmd_err       : one-cycle pulse after an illegal command is accepted
//   o_bp_hit        : one-cycle pulse on a breakpoint stop
// Build option: define PIPE_CTRL_BREAKPOINT_EN to enable the PC breakpoint;
// without it SET_BP is a legal no-op and o_bp_hit stays 0.
module pipeline_run_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int N_STAGES     = 5,
  parameter int NB_CYCLE_CNT = 32,
  parameter int NB_ADDRESS   = 32,
  parameter int NB_CMD       = 3
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  pipeline_run_ctrl_if.slave      cmd_bus,
  input  logic                    i_halt_fetched,
  input  logic [NB_ADDRESS-1:0]   i_pc,
  output logic                    o_pipe_en,
  output logic                    o_fetch_en,
  output logic [1:0]              o_state,
  output logic [NB_CYCLE_CNT-1:0] o_cycle_count,
  output logic                    o_done,
  output logic                    o_cmd_err,
  output logic                    o_bp_hit
);

  localparam int                  DRAIN_CNT_W = drain_width(N_STAGES);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT = DRAIN_CNT_W'(N_STAGES - 1);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(1);

`ifdef PIPE_CTRL_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  state_e                 state, state_d;
  logic                   halt_pending, halt_pending_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt, drain_cnt_d;
  logic                   done_q, cmd_err_q, bp_hit_q;
  logic                   cmd_err_d, bp_hit_d;
  logic                   cmd_ready, cmd_fire;
  logic                   pipe_en;
  logic                   cnt_clear, bp_load, bp_clear, bp_trigger;
  cmd_e                   cmd_code;

  assign cmd_ready           = (state != ST_STEP);
  assign cmd_bus.o_cmd_ready = cmd_ready;
  assign cmd_fire            = cmd_bus.i_cmd_valid & cmd_ready;
  assign cmd_code            = cmd_e'(cmd_bus.i_cmd[2:0]);
  assign pipe_en             = (state == ST_RUN) | (state == ST_STEP);

  assign o_pipe_en  = pipe_en;
  assign o_fetch_en = pipe_en & ~halt_pending;
  assign o_state    = state;
  assign o_done     = done_q;
  assign o_cmd_err  = cmd_err_q;
  assign o_bp_hit   = bp_hit_q;

  // Registered FSM state, drain tracking and the one-cycle status pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      halt_pending <= 1'b0;
      drain_cnt    <= '0;
      done_q       <= 1'b0;
      cmd_err_q    <= 1'b0;
      bp_hit_q     <= 1'b0;
    end else begin
      state        <= state_d;
      halt_pending <= halt_pending_d;
      drain_cnt    <= drain_cnt_d;
      done_q       <= (state_d == ST_DONE) && (state != ST_DONE);
      cmd_err_q    <= cmd_err_d;
      bp_hit_q     <= bp_hit_d;
    end
  end

  // Next-state logic. Later blocks override earlier ones: command handling
  // first, then the STEP auto-return, then a breakpoint stop, and finally
  // drain completion, so reaching DONE beats a simultaneous HALT command.
  always_comb begin
    state_d        = state;
    halt_pending_d = halt_pending;
    drain_cnt_d    = drain_cnt;
    cmd_err_d      = 1'b0;
    bp_hit_d       = 1'b0;
    cnt_clear      = 1'b0;
    bp_load        = 1'b0;
    bp_clear       = 1'b0;

    if (cmd_fire) begin
      unique case (state)
        ST_IDLE: begin
          unique case (cmd_code)
            CMD_RUN:    state_d = ST_RUN;
            CMD_STEP:   state_d = ST_STEP;
            CMD_CLEAR: begin
              cnt_clear      = 1'b1;
              halt_pending_d = 1'b0;
              drain_cnt_d    = '0;
              bp_clear       = 1'b1;
            end
            CMD_SET_BP: bp_load = 1'b1;
            default:    ;
          endcase
        end
        ST_RUN: begin
          unique case (cmd_code)
            CMD_HALT:                      state_d   = ST_IDLE;
            CMD_RUN, CMD_STEP, CMD_CLEAR:  cmd_err_d = 1'b1;
            CMD_SET_BP:                    cmd_err_d = BP_EN;
            default:                       ;
          endcase
        end
        ST_DONE: begin
          unique case (cmd_code)
            CMD_NOP:    ;
            CMD_CLEAR: begin
              state_d        = ST_IDLE;
              cnt_clear      = 1'b1;
              halt_pending_d = 1'b0;
              drain_cnt_d    = '0;
              bp_clear       = 1'b1;
            end
            CMD_SET_BP: bp_load = 1'b1;
            default:    cmd_err_d = 1'b1;
          endcase
        end
        default: ;
      endcase
    end

    if (state == ST_STEP) begin
      state_d = ST_IDLE;
    end

    if (bp_trigger) begin
      state_d  = ST_IDLE;
      bp_hit_d = 1'b1;
    end

    // A HALT seen while already draining is ignored; otherwise it arms the
    // drain. Only enabled cycles advance the drain.
    if (pipe_en) begin
      if (halt_pending) begin
        if (drain_cnt == DRAIN_LAST) begin
          drain_cnt_d = '0;
          state_d     = ST_DONE;
        end else if (drain_cnt != '0) begin
          drain_cnt_d = drain_cnt - DRAIN_LAST;
        end
      end else if (i_halt_fetched) begin
        halt_pending_d = 1'b1;
        drain_cnt_d    = DRAIN_INIT;
      end
    end
  end

`ifdef PIPE_CTRL_BREAKPOINT_EN
  logic [NB_ADDRESS-1:0] bp_addr;
  logic                  bp_valid;
  logic                  bp_mask;
  logic                  bp_match;

  assign bp_match   = bp_valid & (i_pc == bp_addr);
  assign bp_trigger = (state == ST_RUN) & ~halt_pending & bp_match & ~bp_mask;

  // bp_mask stops an immediate re-trigger when RUN resumes on the PC that
  // just stopped us; it lifts once the running PC moves off the address.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bp_addr  <= '0;
      bp_valid <= 1'b0;
      bp_mask  <= 1'b0;
    end else if (bp_clear) begin
      bp_valid <= 1'b0;
      bp_mask  <= 1'b0;
    end else if (bp_load) begin
      bp_addr  <= cmd_bus.i_cmd_data;
      bp_valid <= 1'b1;
      bp_mask  <= 1'b0;
    end else if (bp_trigger) begin
      bp_mask  <= 1'b1;
    end else if ((state == ST_RUN) && !bp_match) begin
      bp_mask  <= 1'b0;
    end
  end
`else
  logic unused_bp;
  assign bp_trigger = 1'b0;
  assign unused_bp  = ^{i_pc, cmd_bus.i_cmd_data, bp_load, bp_clear};
`endif

  pipe_ctrl_sat_counter #(
    .WIDTH (NB_CYCLE_CNT)
  ) u_cycle_counter (
    .clk    (i_clk),
    .reset  (i_reset),
    .enable (pipe_en),
    .clear  (cnt_clear),
    .count  (o_cycle_count)
  );

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// tb_pipeline_run_ctrl
// Self-checking bench for pipeline_run_ctrl: directed scenarios followed by
// randomized commands, all compared cycle by cycle against a behavioural
// model through an expected-output queue drained by a monitor process.
// Follows PIPE_CTRL_BREAKPOINT_EN so the same bench covers both builds.
module tb_pipeline_run_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int    N_STAGES = 5;
  localparam int    M_IDLE   = 0;
  localparam int    M_RUN    = 1;
  localparam int    M_STEP   = 2;
  localparam int    M_DONE   = 3;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;
`ifdef PIPE_CTRL_BREAKPOINT_EN
  localparam bit    BP_EN    = 1'b1;
`else
  localparam bit    BP_EN    = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        halt_fetched;
  logic [31:0] pc;
  logic        pipe_en, fetch_en, done, cmd_err, bp_hit;
  logic [1:0]  state;
  logic [31:0] cycle_count;

  pipeline_run_ctrl_if #(.NB_CMD(3), .NB_ADDRESS(32)) cmd_bus ();

  pipeline_run_ctrl #(
    .N_STAGES     (N_STAGES),
    .NB_CYCLE_CNT (32),
    .NB_ADDRESS   (32),
    .NB_CMD       (3)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .cmd_bus        (cmd_bus.slave),
    .i_halt_fetched (halt_fetched),
    .i_pc           (pc),
    .o_pipe_en      (pipe_en),
    .o_fetch_en     (fetch_en),
    .o_state        (state),
    .o_cycle_count  (cycle_count),
    .o_done         (done),
    .o_cmd_err      (cmd_err),
    .o_bp_hit       (bp_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit     ready;
    bit     pipe_en;
    bit     fetch_en;
    int     st;
    longint cnt;
    bit     done;
    bit     err;
    bit     bphit;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: run mode, "enabled cycles left to drain", pulses.
  int     m_st;
  bit     m_hp;
  int     m_left;
  longint m_cnt;
  bit     m_done, m_err, m_bphit;
  bit     m_bpv, m_bpsup;
  logic [31:0] m_bpa;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_hp = 0; m_left = 0; m_cnt = 0;
    m_done = 0; m_err = 0; m_bphit = 0; m_bpv = 0; m_bpsup = 0; m_bpa = '0;
  endtask

  task automatic model_clear();
    m_cnt = 0; m_hp = 0; m_left = 0; m_bpv = 0; m_bpsup = 0;
  endtask

  task automatic model_set_bp(input logic [31:0] addr);
    if (BP_EN) begin
      m_bpa = addr; m_bpv = 1; m_bpsup = 0;
    end
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.ready    = (m_st != M_STEP);
    e.pipe_en  = (m_st == M_RUN) || (m_st == M_STEP);
    e.fetch_en = e.pipe_en && !m_hp;
    e.st       = m_st;
    e.cnt      = m_cnt;
    e.done     = m_done;
    e.err      = m_err;
    e.bphit    = m_bphit;
    return e;
  endfunction

  task automatic model_update(input bit rst, input bit valid, input logic [2:0] cmd,
                              input logic [31:0] data, input bit halt, input logic [31:0] cur_pc);
    int nxt;
    bit running, accepted;
    if (rst) begin
      model_reset();
      return;
    end
    running  = (m_st == M_RUN) || (m_st == M_STEP);
    accepted = valid && (m_st != M_STEP);
    nxt = m_st; m_err = 0; m_bphit = 0;
    if (running) m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
    if (accepted) begin
      if (m_st == M_IDLE) begin
        if (cmd == 3'd1) nxt = M_RUN;
        else if (cmd == 3'd2) nxt = M_STEP;
        else if (cmd == 3'd4) model_clear();
        else if (cmd == 3'd5) model_set_bp(data);
      end else if (m_st == M_RUN) begin
        if (cmd == 3'd3) nxt = M_IDLE;
        else if (cmd == 3'd1 || cmd == 3'd2 || cmd == 3'd4) m_err = 1;
        else if (cmd == 3'd5) m_err = BP_EN;
      end else if (m_st == M_DONE) begin
        if (cmd == 3'd4) begin nxt = M_IDLE; model_clear(); end
        else if (cmd == 3'd5) begin if (BP_EN) model_set_bp(data); end
        else if (cmd != 3'd0) m_err = 1;
      end
    end
    if (m_st == M_STEP) nxt = M_IDLE;
    if (BP_EN && m_st == M_RUN) begin
      if (m_bpv && !m_hp && cur_pc == m_bpa && !m_bpsup) begin
        nxt = M_IDLE; m_bphit = 1; m_bpsup = 1;
      end else if (cur_pc != m_bpa) begin
        m_bpsup = 0;
      end
    end
    if (running) begin
      if (m_hp) begin
        m_left = m_left - 1;
        if (m_left == 0) nxt = M_DONE;
      end else if (halt) begin
        m_hp = 1; m_left = N_STAGES - 1;
      end
    end
    m_done = (nxt == M_DONE) && (m_st != M_DONE);
    m_st = nxt;
  endtask

  // Called just after a rising edge: queue what this cycle must show, drive
  // the inputs, then advance the model across the next edge.
  task automatic applyStimulus(input bit rst, input bit valid, input logic [2:0] cmd,
                               input logic [31:0] data, input bit halt, input logic [31:0] cur_pc);
    exp_q.push_back(model_outputs());
    reset               = rst;
    cmd_bus.i_cmd_valid = valid;
    cmd_bus.i_cmd       = cmd;
    cmd_bus.i_cmd_data  = data;
    halt_fetched        = halt;
    pc                  = cur_pc;
    @(posedge clk);
    model_update(rst, valid, cmd, data, halt, cur_pc);
    #1;
  endtask

  task automatic idle_cycle(input bit halt, input logic [31:0] cur_pc);
    applyStimulus(0, 0, 3'd0, 32'h0, halt, cur_pc);
  endtask

  task automatic send_cmd(input logic [2:0] cmd, input logic [31:0] data, input logic [31:0] cur_pc);
    applyStimulus(0, 1, cmd, data, 0, cur_pc);
  endtask

  // Monitor: every falling edge compares the DUT against the queued record.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cyc++;
        checkOutput($sformatf("sb_ready@%0d", cyc), longint'(cmd_bus.o_cmd_ready), longint'(e.ready));
        checkOutput($sformatf("sb_pipe_en@%0d", cyc), longint'(pipe_en), longint'(e.pipe_en));
        checkOutput($sformatf("sb_fetch_en@%0d", cyc), longint'(fetch_en), longint'(e.fetch_en));
        checkOutput($sformatf("sb_state@%0d", cyc), longint'(state), longint'(e.st));
        checkOutput($sformatf("sb_cycle_count@%0d", cyc), longint'(cycle_count), e.cnt);
        checkOutput($sformatf("sb_done@%0d", cyc), longint'(done), longint'(e.done));
        checkOutput($sformatf("sb_cmd_err@%0d", cyc), longint'(cmd_err), longint'(e.err));
        checkOutput($sformatf("sb_bp_hit@%0d", cyc), longint'(bp_hit), longint'(e.bphit));
      end
    end
  end

  initial begin
    reset = 1; halt_fetched = 0; pc = '0;
    cmd_bus.i_cmd_valid = 0; cmd_bus.i_cmd = '0; cmd_bus.i_cmd_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", longint'(cmd_bus.o_cmd_ready), 1);
    checkOutput("reset_state", longint'(state), 0);

    // Full run with a fetched HALT on the 11th enabled cycle.
    send_cmd(3'd1, 0, 0);
    for (int k = 0; k < 15; k++) idle_cycle(k == 10, 32'h100 + 4 * k);
    checkOutput("tp1_state_done", longint'(state), 3);
    checkOutput("tp1_done_pulse", longint'(done), 1);
    checkOutput("tp1_cycle_count", longint'(cycle_count), 15);

    // RUN is illegal in DONE, CLEAR returns to IDLE.
    send_cmd(3'd1, 0, 0);
    checkOutput("done_run_err", longint'(cmd_err), 1);
    checkOutput("done_run_state", longint'(state), 3);
    send_cmd(3'd4, 0, 0);
    checkOutput("clear_state", longint'(state), 0);
    checkOutput("clear_count", longint'(cycle_count), 0);

    // Three single steps.
    for (int k = 0; k < 3; k++) begin
      send_cmd(3'd2, 0, 0);
      checkOutput("step_pipe_en", longint'(pipe_en), 1);
      idle_cycle(0, 0);
      checkOutput("step_back_idle", longint'(state), 0);
    end
    checkOutput("step_count", longint'(cycle_count), 3);

    // Drain interrupted by a HALT command and resumed.
    send_cmd(3'd4, 0, 0);
    send_cmd(3'd1, 0, 0);
    idle_cycle(1, 0);
    idle_cycle(0, 0);
    send_cmd(3'd3, 0, 0);
    checkOutput("pause_state", longint'(state), 0);
    send_cmd(3'd1, 0, 0);
    idle_cycle(0, 0);
    idle_cycle(0, 0);
    checkOutput("resume_state_done", longint'(state), 3);
    checkOutput("resume_count", longint'(cycle_count), 5);
    send_cmd(3'd4, 0, 0);

    // Reset in the middle of a drain.
    send_cmd(3'd1, 0, 0);
    idle_cycle(1, 0);
    idle_cycle(0, 0);
    applyStimulus(1, 0, 3'd0, 0, 0, 0);
    checkOutput("rst_pipe_en", longint'(pipe_en), 0);
    checkOutput("rst_count", longint'(cycle_count), 0);
    send_cmd(3'd1, 0, 0);
    checkOutput("rst_fetch_en", longint'(fetch_en), 1);
    send_cmd(3'd3, 0, 0);

`ifdef PIPE_CTRL_BREAKPOINT_EN
    // Breakpoint stop, then no re-trigger on the same PC.
    send_cmd(3'd5, 32'h20, 32'h10);
    send_cmd(3'd1, 0, 32'h10);
    idle_cycle(0, 32'h14);
    idle_cycle(0, 32'h20);
    checkOutput("bp_hit_pulse", longint'(bp_hit), 1);
    checkOutput("bp_state_idle", longint'(state), 0);
    send_cmd(3'd1, 0, 32'h20);
    for (int k = 0; k < 3; k++) idle_cycle(0, 32'h20);
    checkOutput("bp_no_retrigger", longint'(state), 1);
    send_cmd(3'd3, 0, 32'h20);
`endif

    // Randomized commands, halts, PCs and occasional resets.
    for (int i = 0; i < 800; i++) begin
      bit          r, v, h;
      int          sel;
      logic [2:0]  c;
      logic [31:0] d, p;
      r   = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 9) < 4);
      sel = $urandom_range(0, 99);
      c   = (sel < 10) ? 3'd0 : (sel < 40) ? 3'd1 : (sel < 55) ? 3'd2 :
            (sel < 70) ? 3'd3 : (sel < 85) ? 3'd4 : 3'd5;
      d   = ($urandom_range(0, 1) == 1) ? 32'h20 : 32'h24;
      h   = ($urandom_range(0, 99) < 8);
      sel = $urandom_range(0, 3);
      p   = (sel == 0) ? 32'h20 : (sel == 1) ? 32'h24 : 32'($urandom);
      applyStimulus(r, v, c, d, h, p);
    end
    idle_cycle(0, 0);

    @(negedge clk);
    #1;
    checkOutput("queue_drained", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
